result_checker: RTL
===================

# result_checker

Self-checking stage downstream of the adder-comparison top. It observes the operand pair presented to the adder stage (A, B) and the registered 40-bit Result that comes back. It compares each Result against a locally computed A+B after a fixed pipeline latency, and reports a saturating mismatch count, pass/fail and the first failing pair, so both adder implementations can be run on silicon/FPGA without an external scoreboard.

## Interface
- LATENCY, 2, edges from operand capture to Result valid in the adder stage (legal 1..8)
- NUM_SAMPLES, 1024, operand pairs checked per run (legal 1..65535)
- CNT_W, 16, width of err_cnt
- clk  input  1  rising-edge clock shared with the adder stage
- nRST  input  1  reset; one clock; reset is asynchronous and active-low
- start  input  1  single-cycle pulse; begins a run from IDLE
- in_valid  input  1  A/B this cycle are a sample driven into the adder stage
- A  input  32  operand A as driven to the adder stage
- B  input  32  operand B as driven to the adder stage
- Result  input  40  registered sum from the adder stage
- busy  output  1  high in RUN and DRAIN
- done  output  1  one-cycle pulse when the final comparison is counted
- pass  output  1  err_cnt == 0 at end of run; held until next start
- err_cnt  output  CNT_W  mismatch count, saturates at all-ones
- first_err_exp  output  40  expected value of first mismatch
- first_err_got  output  40  Result of first mismatch

## Operation
- Expected = zero-extend(A) + zero-extend(B), 40 bits, carry-in 0. Bits 39:33 are always 0. Independent of the adder-stage Sel.
- Delay line: LATENCY stages of {valid, expected[39:0]}. Stage 0 loads at every edge with {in_valid && state==RUN && accepted<NUM_SAMPLES, expected}.
- Compare when tail.valid: mismatch = (Result != tail.expected). All 40 bits are compared.
- FSM:
  - IDLE: start → RUN; clears err_cnt, accepted, checked, first_err_*, pass=0.
  - RUN: accepted increments per qualified sample. When accepted reaches NUM_SAMPLES → DRAIN.
  - DRAIN: no new samples. When checked reaches NUM_SAMPLES → DONE.
  - DONE: one cycle, done=1, pass=(err_cnt==0) → IDLE.
- A compare can complete in RUN or DRAIN. checked increments on every tail.valid compare.
- start outside IDLE is ignored. in_valid outside RUN is ignored.
- err_cnt saturates at 2^CNT_W−1; it does not wrap.
- Reset values: busy 0, done 0, pass 0, err_cnt 0, first_err_* 0, state IDLE, delay line valids 0.
- nRST asserted mid-run aborts immediately. No done pulse is produced and no pass is reported.

## Timing
- Sample with in_valid high before edge k is accepted at edge k. Its Result is compared during the cycle ending at edge k+LATENCY. err_cnt and first_err_* update at edge k+LATENCY.
- Back-to-back samples are supported, one per cycle.
- Run with NUM_SAMPLES all-consecutive samples: busy for NUM_SAMPLES+LATENCY cycles, then done for 1 cycle.
- When the last compare and a saturating increment occur on the same edge, the final err_cnt includes that compare.
- done and pass update on the same edge. pass is valid from that edge onward.

## Configuration
- RESULT_CHECKER_FIRST_ERR_EN defined: first_err_exp and first_err_got load on the first mismatch of a run and then hold.
- Not defined: the capture registers are omitted, and first_err_exp and first_err_got are constant 0. Counting and pass/fail are unaffected.

## Structure
- result_checker_pkg holds:
  - OPERAND_W=32 and RESULT_W=40
  - state enum {IDLE, RUN, DRAIN, DONE}
  - the delay-line entry struct {valid, expected}
- Sub-module result_checker_delay: parameterised LATENCY-deep shift pipeline of entries with async active-low clear. The top holds the FSM, counters and compare.

## Test plan
- Reset, then start, then 1024 consecutive samples A=i, B=3·i with a correct model driving Result → done once at cycle 1024+2 after the first sample; pass=1; err_cnt=0.
- Sample A=0xFFFF_FFFF, B=0xFFFF_FFFF → expected 0x01_FFFF_FFFE. Drive that value: no error. Drive 0x00_FFFF_FFFE: err_cnt=1; first_err_exp=0x01FFFFFFFE; first_err_got=0x00FFFFFFFE (macro on).
- Corrupt samples 5 and 9 → err_cnt=2; first_err_* hold sample-5 values; pass=0.
- CNT_W=2, five mismatches → err_cnt saturates at 3; pass=0.
- in_valid gaps (every other cycle) and start pulsed during RUN → the run still checks exactly NUM_SAMPLES samples; the extra start has no effect.
- nRST dropped during DRAIN → all outputs 0 immediately. A new start after release runs cleanly to pass=1.

Source files
------------

// File: rtl/result_checker_pkg.sv
// result_checker_pkg
//   Shared types and constants for the result checker:
//     OPERAND_W / RESULT_W  - adder operand and result widths
//     state_t               - run-control FSM states
//     entry_t               - one delay-line slot {valid, expected}
//     expected_sum()        - reference sum of two operands
package result_checker_pkg;

   localparam int OPERAND_W = 32;
   localparam int RESULT_W  = 40;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic                valid;
      logic [RESULT_W-1:0] expected;
   } entry_t;

   // Zero-extended sum with carry-in 0; bits 39:33 always end up 0.
   function automatic logic [RESULT_W-1:0] expected_sum(
      input logic [OPERAND_W-1:0] a,
      input logic [OPERAND_W-1:0] b
   );
      return {{(RESULT_W-OPERAND_W){1'b0}}, a} + {{(RESULT_W-OPERAND_W){1'b0}}, b};
   endfunction

endpackage

// File: rtl/result_checker_delay.sv
// result_checker_delay
//   LATENCY-deep shift pipeline of {valid, expected} entries. Aligns the
//   locally computed sum with the Result returned by the adder stage.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low clear of the valid bits
//     head  - entry loaded into stage 0 at every edge
//     tail  - entry leaving stage LATENCY-1
module result_checker_delay
   import result_checker_pkg::*;
#(
   parameter int LATENCY = 2
) (
   input  logic   clk,
   input  logic   rst_n,
   input  entry_t head,
   output entry_t tail
);

   logic [LATENCY-1:0]  vld_p;
   logic [RESULT_W-1:0] exp_p [LATENCY];

   // Valid bits are control and carry the reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= head.valid;
         for (int i = 1; i < LATENCY; i++) begin
            vld_p[i] <= vld_p[i-1];
         end
      end
   end

   // Expected values are data; they are only meaningful alongside a valid.
   always_ff @(posedge clk) begin
      exp_p[0] <= head.expected;
      for (int i = 1; i < LATENCY; i++) begin
         exp_p[i] <= exp_p[i-1];
      end
   end

   assign tail.valid    = vld_p[LATENCY-1];
   assign tail.expected = exp_p[LATENCY-1];

endmodule

// File: rtl/result_checker.sv
// result_checker
//   Observes operand pairs driven into the adder stage and the registered
//   Result returned LATENCY edges later; counts mismatches, reports pass/fail
//   and optionally captures the first failing pair.
//   Optional feature macro: RESULT_CHECKER_FIRST_ERR_EN (first-error capture).
//   Ports:
//     clk, nRST       - clock, asynchronous active-low reset
//     start           - pulse in IDLE begins a run
//     in_valid, A, B  - sample presented to the adder stage
//     Result          - registered 40-bit sum from the adder stage
//     busy            - high in RUN and DRAIN
//     done            - one-cycle pulse when the final compare is counted
//     pass            - err_cnt == 0 at end of run, held until next start
//     err_cnt         - saturating mismatch count
//     first_err_exp/got - expected/observed value of first mismatch
module result_checker
   import result_checker_pkg::*;
#(
   parameter int LATENCY     = 2,
   parameter int NUM_SAMPLES = 1024,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 nRST,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [OPERAND_W-1:0] A,
   input  logic [OPERAND_W-1:0] B,
   input  logic [RESULT_W-1:0]  Result,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [RESULT_W-1:0]  first_err_exp,
   output logic [RESULT_W-1:0]  first_err_got
);

   localparam int                SMP_W    = 17;
   localparam logic [SMP_W-1:0]  SMP_LAST = SMP_W'(NUM_SAMPLES);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_t           state, state_nxt;
   logic [SMP_W-1:0] accepted, accepted_nxt;
   logic [SMP_W-1:0] checked, checked_nxt;
   logic [CNT_W-1:0] err_nxt;
   logic             take;
   logic             mismatch;
   logic             clear;
   entry_t           head, tail;

   // Stage 0: qualify the sample and form its expected sum.
   assign take          = in_valid && (state == RUN) && (accepted < SMP_LAST);
   assign head.valid    = take;
   assign head.expected = expected_sum(A, B);

   result_checker_delay #(
      .LATENCY (LATENCY)
   ) u_delay (
      .clk   (clk),
      .rst_n (nRST),
      .head  (head),
      .tail  (tail)
   );

   // Tail stage: compare against the returned Result.
   assign mismatch     = tail.valid && (Result != tail.expected);
   assign accepted_nxt = accepted + SMP_W'(take);
   assign checked_nxt  = checked + SMP_W'(tail.valid);
   assign err_nxt      = mismatch ? sat_inc(err_cnt) : err_cnt;
   assign clear        = (state == IDLE) && start;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (accepted_nxt == SMP_LAST) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (checked_nxt == SMP_LAST) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         accepted <= '0;
         checked  <= '0;
         err_cnt  <= '0;
         pass     <= 1'b0;
      end else if (clear) begin
         accepted <= '0;
         checked  <= '0;
         err_cnt  <= '0;
         pass     <= 1'b0;
      end else begin
         accepted <= accepted_nxt;
         checked  <= checked_nxt;
         err_cnt  <= err_nxt;
         // pass uses err_nxt so a mismatch on the final compare is included.
         if ((state == DRAIN) && (state_nxt == DONE)) begin
            pass <= (err_nxt == '0);
         end
      end
   end

`ifdef RESULT_CHECKER_FIRST_ERR_EN
   logic [RESULT_W-1:0] fexp_q, fgot_q;

   // err_cnt is still zero only for the first mismatch of the run.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         fexp_q <= '0;
         fgot_q <= '0;
      end else if (clear) begin
         fexp_q <= '0;
         fgot_q <= '0;
      end else if (mismatch && (err_cnt == '0)) begin
         fexp_q <= tail.expected;
         fgot_q <= Result;
      end
   end

   assign first_err_exp = fexp_q;
   assign first_err_got = fgot_q;
`else
   assign first_err_exp = '0;
   assign first_err_got = '0;
`endif

endmodule
